// File: rtl/rf_pkg.sv
// Shared widths and dependency-tag definitions for the renaming register file.
// NON_DEP is the tag value meaning "no in-flight producer, value is architectural".
package rf_pkg;
   localparam int RF_ROB_WIDTH  = 3;
   localparam int RF_REG_WIDTH  = 5;
   localparam int RF_XLEN       = 32;
   localparam int RF_CKPT_WIDTH = 2;

   typedef logic [RF_ROB_WIDTH:0] dep_t;

   localparam dep_t NON_DEP = dep_t'(1 << RF_ROB_WIDTH);

   // NON_DEP for an arbitrary RoB index width.
   function automatic int non_dep_of(input int rob_width);
      return 1 << rob_width;
   endfunction
endpackage

// File: rtl/rf_ckpt_bank.sv
// Checkpoint storage: CKPT_DEPTH snapshots of the dependency table, with commit match-clear on live slots.
// Latency: combinational read of one slot, one-cycle write/clear; no backpressure (caller gates enables).
module rf_ckpt_bank
   import rf_pkg::*;
#(
   parameter int ROB_WIDTH  = RF_ROB_WIDTH,
   parameter int REG_WIDTH  = RF_REG_WIDTH,
   parameter int CKPT_WIDTH = RF_CKPT_WIDTH
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    wr_en,
   input  logic [CKPT_WIDTH-1:0]   wr_idx,
   input  logic [ROB_WIDTH:0]      wr_tags [(1 << REG_WIDTH)],
   input  logic                    clr_en,
   input  logic [REG_WIDTH-1:0]    clr_reg,
   input  logic [ROB_WIDTH-1:0]    clr_rob,
   input  logic [(1 << CKPT_WIDTH)-1:0] slot_vld,
   input  logic [CKPT_WIDTH-1:0]   rd_idx,
   output logic [ROB_WIDTH:0]      rd_tags [(1 << REG_WIDTH)]
);
   localparam int NREG       = 1 << REG_WIDTH;
   localparam int CKPT_DEPTH = 1 << CKPT_WIDTH;
   localparam logic [ROB_WIDTH:0] TAG_READY = (ROB_WIDTH+1)'(non_dep_of(ROB_WIDTH));

   logic [ROB_WIDTH:0] slot_q [CKPT_DEPTH][NREG];
   logic [ROB_WIDTH:0] slot_d [CKPT_DEPTH][NREG];
   logic [ROB_WIDTH:0] clr_tag;

   assign clr_tag = {1'b0, clr_rob};

   always_comb begin
      slot_d = slot_q;
      for (int k = 0; k < CKPT_DEPTH; k++) begin
         if (clr_en && slot_vld[k] && slot_q[k][clr_reg] == clr_tag)
            slot_d[k][clr_reg] = TAG_READY;
      end
      // The write slot is never live, so the fresh snapshot simply replaces it.
      if (wr_en)
         slot_d[wr_idx] = wr_tags;
   end

   always_comb begin
      rd_tags = slot_q[rd_idx];
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int k = 0; k < CKPT_DEPTH; k++)
            for (int r = 0; r < NREG; r++)
               slot_q[k][r] <= TAG_READY;
      end else begin
         slot_q <= slot_d;
      end
   end
endmodule

// File: rtl/rf_ckpt.sv
// Register file with rename tags and a circular FIFO of dependency-table checkpoints for branch recovery.
// Latency: combinational source query, one-cycle state update; no backpressure, rdy_in low freezes all state.
module rf_ckpt
   import rf_pkg::*;
#(
   parameter int ROB_WIDTH  = RF_ROB_WIDTH,
   parameter int REG_WIDTH  = RF_REG_WIDTH,
   parameter int XLEN       = RF_XLEN,
   parameter int CKPT_WIDTH = RF_CKPT_WIDTH
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  flush_in,
   input  logic                  commit_en,
   input  logic [REG_WIDTH-1:0]  commit_reg,
   input  logic [ROB_WIDTH-1:0]  commit_rob,
   input  logic [XLEN-1:0]       commit_data,
   input  logic [REG_WIDTH-1:0]  rs1,
   input  logic [REG_WIDTH-1:0]  rs2,
   output logic [ROB_WIDTH:0]    Qj,
   output logic [ROB_WIDTH:0]    Qk,
   output logic [XLEN-1:0]       Vj,
   output logic [XLEN-1:0]       Vk,
   input  logic                  new_en,
   input  logic [ROB_WIDTH-1:0]  new_rob,
   input  logic [REG_WIDTH-1:0]  new_rd,
   input  logic                  ckpt_save_en,
   output logic [CKPT_WIDTH-1:0] ckpt_id,
   input  logic                  ckpt_restore_en,
   input  logic [CKPT_WIDTH-1:0] ckpt_restore_id,
   input  logic                  ckpt_release_en,
   output logic                  ckpt_full,
   output logic [CKPT_WIDTH:0]   ckpt_count
);
   localparam int NREG       = 1 << REG_WIDTH;
   localparam int CKPT_DEPTH = 1 << CKPT_WIDTH;
   localparam logic [ROB_WIDTH:0]  TAG_READY = (ROB_WIDTH+1)'(non_dep_of(ROB_WIDTH));
   localparam logic [CKPT_WIDTH:0] DEPTH_CNT = (CKPT_WIDTH+1)'(CKPT_DEPTH);

   logic [XLEN-1:0]       regs_q   [NREG];
   logic [XLEN-1:0]       regs_d   [NREG];
   logic [ROB_WIDTH:0]    dep_q    [NREG];
   logic [ROB_WIDTH:0]    dep_d    [NREG];
   logic [ROB_WIDTH:0]    dep_post [NREG];
   logic [ROB_WIDTH:0]    rd_tags  [NREG];
   logic [CKPT_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
   logic [CKPT_WIDTH:0]   count_q, count_d;

   logic [ROB_WIDTH:0]    commit_tag, new_tag;
   logic                  commit_wr, rename_wr;
   logic [CKPT_DEPTH-1:0] slot_vld;
   logic [CKPT_WIDTH-1:0] restore_off;
   logic                  restore_ok;
   logic                  save_do, release_do;
   logic [REG_WIDTH-1:0]  rs_sel [2];
   logic [ROB_WIDTH:0]    q_out  [2];
   logic [XLEN-1:0]       v_out  [2];

   assign commit_tag = {1'b0, commit_rob};
   assign new_tag    = {1'b0, new_rob};
   assign commit_wr  = commit_en && (commit_reg != '0);
   assign rename_wr  = new_en && (new_rd != '0);

   // Source query: bypass a same-cycle commit so the dispatcher never waits an extra cycle.
   assign rs_sel[0] = rs1;
   assign rs_sel[1] = rs2;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         q_out[i] = dep_q[rs_sel[i]];
         v_out[i] = '0;
         if (flush_in || rs_sel[i] == '0 || (commit_en && dep_q[rs_sel[i]] == commit_tag))
            q_out[i] = TAG_READY;
         if (q_out[i] == TAG_READY)
            v_out[i] = (dep_q[rs_sel[i]] != TAG_READY) ? commit_data : regs_q[rs_sel[i]];
      end
   end

   assign Qj = q_out[0];
   assign Qk = q_out[1];
   assign Vj = v_out[0];
   assign Vk = v_out[1];

   // Live slots are head .. head+count-1 modulo depth.
   always_comb begin
      for (int k = 0; k < CKPT_DEPTH; k++)
         slot_vld[k] = {1'b0, CKPT_WIDTH'(k) - head_q} < count_q;
   end

   assign restore_off = ckpt_restore_id - head_q;
   assign restore_ok  = ckpt_restore_en && ({1'b0, restore_off} < count_q);

   // Dependency table as it stands after this cycle's commit clear and rename.
   always_comb begin
      dep_post = dep_q;
      if (commit_wr && dep_q[commit_reg] == commit_tag)
         dep_post[commit_reg] = TAG_READY;
      if (rename_wr)
         dep_post[new_rd] = new_tag;
   end

   always_comb begin
      regs_d     = regs_q;
      dep_d      = dep_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      save_do    = 1'b0;
      release_do = 1'b0;
      if (rdy_in) begin
         if (flush_in) begin
            for (int r = 0; r < NREG; r++)
               dep_d[r] = TAG_READY;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end else begin
            if (commit_wr)
               regs_d[commit_reg] = commit_data;
            release_do = ckpt_release_en && (count_q != '0);
            if (restore_ok) begin
               dep_d = rd_tags;
               if (commit_wr && rd_tags[commit_reg] == commit_tag)
                  dep_d[commit_reg] = TAG_READY;
               tail_d  = ckpt_restore_id;
               count_d = {1'b0, restore_off};
               if (release_do) begin
                  head_d = head_q + CKPT_WIDTH'(1);
                  // Restoring to the oldest slot while releasing it empties the FIFO; keep tail on head.
                  if (restore_off == '0)
                     tail_d = head_q + CKPT_WIDTH'(1);
                  else
                     count_d = count_d - (CKPT_WIDTH+1)'(1);
               end
            end else begin
               dep_d   = dep_post;
               save_do = ckpt_save_en && (count_q != DEPTH_CNT);
               if (save_do)
                  tail_d = tail_q + CKPT_WIDTH'(1);
               if (release_do)
                  head_d = head_q + CKPT_WIDTH'(1);
               count_d = count_q + (CKPT_WIDTH+1)'(save_do) - (CKPT_WIDTH+1)'(release_do);
            end
         end
      end
   end

   rf_ckpt_bank #(
      .ROB_WIDTH  (ROB_WIDTH),
      .REG_WIDTH  (REG_WIDTH),
      .CKPT_WIDTH (CKPT_WIDTH)
   ) u_bank (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .wr_en    (save_do),
      .wr_idx   (tail_q),
      .wr_tags  (dep_post),
      .clr_en   (rdy_in && !flush_in && commit_wr),
      .clr_reg  (commit_reg),
      .clr_rob  (commit_rob),
      .slot_vld (slot_vld),
      .rd_idx   (ckpt_restore_id),
      .rd_tags  (rd_tags)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= '0;
            dep_q[r]  <= TAG_READY;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         regs_q  <= regs_d;
         dep_q   <= dep_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign ckpt_id    = tail_q;
   assign ckpt_full  = (count_q == DEPTH_CNT);
   assign ckpt_count = count_q;
endmodule

// File: doc/rf_ckpt.md
RF_CKPT -- requirements
Module: rf_ckpt

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 3, meaning RoB index width; NON_DEP = 1<<ROB_WIDTH.
REQ-002 SHALL have parameter REG_WIDTH, default 5, meaning architectural register index width (2**REG_WIDTH registers).
REQ-003 SHALL have parameter XLEN, default 32, meaning register data width.
REQ-004 SHALL have parameter CKPT_WIDTH, default 2, meaning checkpoint id width; CKPT_DEPTH = 1<<CKPT_WIDTH.
REQ-005 SHALL have clk_in, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have rst_in, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have rdy_in, input, 1, global enable; low holds all state.
REQ-008 SHALL have flush_in, input, 1, full pipeline flush from RoB.
REQ-009 SHALL have commit_en / commit_reg / commit_rob / commit_data, inputs, 1 / REG_WIDTH / ROB_WIDTH / XLEN, RoB commit write.
REQ-010 SHALL have rs1, rs2, inputs, REG_WIDTH, dispatcher source queries.
REQ-011 SHALL have Qj, Qk, outputs, ROB_WIDTH+1, producer tag; NON_DEP means value ready.
REQ-012 SHALL have Vj, Vk, outputs, XLEN, source values (0 when dependent).
REQ-013 SHALL have new_en / new_rob / new_rd, inputs, 1 / ROB_WIDTH / REG_WIDTH, rename of destination.
REQ-014 SHALL have ckpt_save_en, input, 1, snapshot request (branch dispatch); ckpt_id, output, CKPT_WIDTH, id the next save receives.
REQ-015 SHALL have ckpt_restore_en / ckpt_restore_id, inputs, 1 / CKPT_WIDTH, mispredict recovery.
REQ-016 SHALL have ckpt_release_en, input, 1, oldest checkpoint resolved correct.
REQ-017 SHALL have ckpt_full, output, 1, and ckpt_count, output, CKPT_WIDTH+1, occupancy.

Function
REQ-018 Query: Q = NON_DEP if flush_in, rs==0, or (commit_en and dep[rs]==commit_rob); else dep[rs].
REQ-019 Value: commit_data if Q==NON_DEP and dep[rs]!=NON_DEP; registers[rs] if Q==NON_DEP; else 0.
REQ-020 Commit (reg!=0): registers[reg] <= data; dep[reg] <= NON_DEP only if dep[reg]==commit_rob; same match-clear applied to every valid checkpoint.
REQ-021 Rename (rd!=0): dep[rd] <= new_rob; rename wins over same-cycle commit clear on same register.
REQ-022 Save: checkpoints form circular FIFO (head, tail, count); save writes dep-table as it will be after this cycle's commit and rename into slot tail; tail+1, count+1; ckpt_id = tail.
REQ-023 Save when count==CKPT_DEPTH SHALL be ignored; ckpt_full = (count==CKPT_DEPTH).
REQ-024 Release: head+1, count-1; ignored when count==0.
REQ-025 Restore id (valid only if within head..tail-1 modulo depth, else ignored): dep <= slot[id] with same-cycle commit match-clear applied; tail <= id; count <= (id-head) mod CKPT_DEPTH; registers untouched; new_en and ckpt_save_en ignored that cycle.
REQ-026 Restore + release same cycle: both apply; if restore_id==head, count ends 0 and head+1.
REQ-027 flush_in: all dep <= NON_DEP, head=tail=count=0; commit, rename, checkpoint inputs ignored; overrides restore.
REQ-028 Priority per cycle: rst_in > !rdy_in > flush_in > restore > (commit, rename, save, release).
REQ-029 Register 0 SHALL always read 0 with Q=NON_DEP and never be renamed.

Reset
REQ-030 rst_in SHALL asynchronously clear registers to 0, dep to NON_DEP, head/tail/count to 0; ckpt_full=0, ckpt_id=0, ckpt_count=0.
REQ-031 Reset mid-operation SHALL discard all checkpoints immediately, not at next edge.

Structure
REQ-032 NON_DEP, width parameters and dependency-tag type SHALL live in shared package rf_pkg.
REQ-033 Checkpoint storage with match-clear SHALL be sub-module rf_ckpt_bank (CKPT_DEPTH x 2**REG_WIDTH tags).
REQ-034 Query path SHALL be combinational; state change latency one cycle.

Verification
REQ-035 Rename x5->rob3, same cycle query rs1=5 -> Qj=NON_DEP (old); next cycle Qj=3, Vj=0.
REQ-036 Commit x5 rob3 data 0xDEAD while rs1=5 queried -> Qj=NON_DEP, Vj=0xDEAD same cycle.
REQ-037 Rename x1->rob1, save (id0), rename x1->rob4, restore id0 -> x1 tag 1, count 0.
REQ-038 Save id0, commit x1 rob1, restore id0 -> x1 NON_DEP, registers[1] holds committed value.
REQ-039 Four saves -> ckpt_full=1; fifth ignored, count stays 4; release -> count 3, full 0.
REQ-040 Rename x2->rob2, save, assert rst_in mid-cycle -> dep NON_DEP, count 0 before next edge.
